// File: rtl/mxint_tile_quantiser.sv
// MX integer tile quantiser: quantises each incoming row into k-element blocks
// (bit_width mantissas plus one shared shift) and double-buffers ROWS rows into tiles.
module mxint_tile_quantiser #(
  parameter int ROWS        = 4,
  parameter int COLS        = 8,
  parameter int k           = 2,
  parameter int in_width    = 16,
  parameter int bit_width   = 8,
  parameter int scale_width = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_row_valid,
  output logic                          o_row_ready,
  input  logic signed [in_width-1:0]    i_row [COLS],
  output logic                          o_tile_valid,
  input  logic                          i_tile_ready,
  output logic signed [bit_width-1:0]   o_M [ROWS][COLS],
  output logic [scale_width-1:0]        o_S [ROWS][COLS/k]
);

  localparam int NB   = COLS / k;
  localparam int SMAX = in_width - bit_width;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic signed [in_width-1:0] MAXV =
    {{(in_width-bit_width+1){1'b0}}, {(bit_width-1){1'b1}}};
  localparam logic signed [in_width-1:0] MINV =
    {{(in_width-bit_width+1){1'b1}}, {(bit_width-1){1'b0}}};

  localparam logic [1:0] EMPTY   = 2'd0;
  localparam logic [1:0] FILLING = 2'd1;
  localparam logic [1:0] FULL    = 2'd2;

  logic [1:0]                  bank_q [2];
  logic [1:0]                  bank_d [2];
  logic                        wr_bank_q, wr_bank_d;
  logic                        rd_bank_q, rd_bank_d;
  logic [RW-1:0]               row_cnt_q, row_cnt_d;
  logic signed [bit_width-1:0] mant_q  [2][ROWS][COLS];
  logic signed [bit_width-1:0] mant_d  [2][ROWS][COLS];
  logic [scale_width-1:0]      scale_q [2][ROWS][NB];
  logic [scale_width-1:0]      scale_d [2][ROWS][NB];

  logic signed [bit_width-1:0] q_mant  [COLS];
  logic [scale_width-1:0]      q_scale [NB];
  logic signed [in_width-1:0]  shifted;
  logic                        fits;
  logic                        row_acc, tile_acc, last_row;

  // Scan shifts from largest to smallest so the smallest shift that fits the whole block wins.
  always_comb begin
    shifted = '0;
    fits    = 1'b0;
    for (int b = 0; b < NB; b++) begin
      q_scale[b] = scale_width'(SMAX);
      for (int s = SMAX; s >= 0; s--) begin
        fits = 1'b1;
        for (int j = 0; j < k; j++) begin
          shifted = i_row[b*k+j] >>> s;
          if (shifted > MAXV || shifted < MINV) fits = 1'b0;
        end
        if (fits) q_scale[b] = scale_width'(s);
      end
      for (int j = 0; j < k; j++) begin
        shifted          = i_row[b*k+j] >>> q_scale[b];
        q_mant[b*k+j]    = shifted[bit_width-1:0];
      end
    end
  end

  assign o_row_ready  = (bank_q[wr_bank_q] != FULL);
  assign o_tile_valid = (bank_q[rd_bank_q] == FULL);
  assign row_acc      = i_row_valid && o_row_ready;
  assign tile_acc     = o_tile_valid && i_tile_ready;
  assign last_row     = (row_cnt_q == RW'(ROWS-1));

  // Row and tile handshakes always target different banks, so both apply in the same cycle.
  always_comb begin
    bank_d    = bank_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    row_cnt_d = row_cnt_q;
    mant_d    = mant_q;
    scale_d   = scale_q;
    if (tile_acc) begin
      bank_d[rd_bank_q] = EMPTY;
      rd_bank_d         = ~rd_bank_q;
    end
    if (row_acc) begin
      for (int c = 0; c < COLS; c++) mant_d[wr_bank_q][row_cnt_q][c] = q_mant[c];
      for (int b = 0; b < NB; b++)   scale_d[wr_bank_q][row_cnt_q][b] = q_scale[b];
      if (last_row) begin
        bank_d[wr_bank_q] = FULL;
        row_cnt_d         = '0;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        bank_d[wr_bank_q] = FILLING;
        row_cnt_d         = row_cnt_q + RW'(1);
      end
    end
  end

  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) o_M[r][c] = mant_q[rd_bank_q][r][c];
      for (int b = 0; b < NB; b++)   o_S[r][b] = scale_q[rd_bank_q][r][b];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      row_cnt_q <= '0;
      for (int n = 0; n < 2; n++) begin
        bank_q[n] <= EMPTY;
        for (int r = 0; r < ROWS; r++) begin
          for (int c = 0; c < COLS; c++) mant_q[n][r][c] <= '0;
          for (int b = 0; b < NB; b++)   scale_q[n][r][b] <= '0;
        end
      end
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      row_cnt_q <= row_cnt_d;
      bank_q    <= bank_d;
      mant_q    <= mant_d;
      scale_q   <= scale_d;
    end
  end

endmodule
